// File: rtl/wb_pkg.sv
// wb_pkg: shared types, parameter legality check and ch0 load-data formatting for the write-back arbiter
package wb_pkg;

    typedef enum logic [1:0] {
        LS_BYTE  = 2'd0,
        LS_HALF  = 2'd1,
        LS_WORD  = 2'd2,
        LS_DWORD = 2'd3
    } load_size_e;

    // Legal configurations: 32/64-bit datapath, 2..8 channels, power-of-two FIFO depth of at least 2
    function automatic bit params_ok(input int data_w, input int num_ch, input int fifo_depth);
        return (data_w == 32 || data_w == 64) && num_ch >= 2 && num_ch <= 8 &&
               fifo_depth >= 2 && (fifo_depth & (fifo_depth - 1)) == 0;
    endfunction

    // Extract the addressed lane (offset aligned down to the access size) and extend to 64 bits;
    // callers truncate to their datapath width
    function automatic logic [63:0] format_load(input logic [63:0] mem, input logic [1:0] size,
                                                input logic uns, input logic [2:0] off);
        logic [2:0]  lane;
        logic [63:0] sh;
        lane = (size == LS_BYTE) ? off :
               (size == LS_HALF) ? {off[2:1], 1'b0} :
               (size == LS_WORD) ? {off[2], 2'b00} : 3'd0;
        sh = mem >> {lane, 3'b000};
        return (size == LS_BYTE) ? {{56{~uns & sh[7]}}, sh[7:0]} :
               (size == LS_HALF) ? {{48{~uns & sh[15]}}, sh[15:0]} :
               (size == LS_WORD) ? {{32{~uns & sh[31]}}, sh[31:0]} : sh;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO with registered full/empty flags; push is refused while full, even if popping
module wb_fifo
#(
    parameter int W     = 37,
    parameter int DEPTH = 4
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          do_push, do_pop;
    logic [W-1:0]  mem_q [DEPTH];

    // Next pointer/occupancy state; pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        do_push = push & ~full_q;
        do_pop  = pop & ~empty_q;
        wr_d    = wr_q + PW'(do_push);
        rd_d    = rd_q + PW'(do_pop);
        cnt_d   = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        full_d  = cnt_d == (PW+1)'(DEPTH);
        empty_d = cnt_d == '0;
    end

    // Pointer and flag registers; reset discards all queued entries at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage needs no reset: stale words are unreachable once the pointers are cleared
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the in-order ch0 stream with buffered aux result channels onto one register-file write port
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
)
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         p_valid,
    input  logic [DATA_W-1:0]            p_mem_data,
    input  logic [DATA_W-1:0]            p_alu_result,
    input  logic [ADDR_W-1:0]            p_dest_reg,
    input  logic                         p_mem_to_reg,
    input  logic                         p_reg_write,
    input  logic [1:0]                   p_load_size,
    input  logic                         p_load_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0]  p_byte_off,
    input  logic [NUM_CH-2:0]            aux_valid,
    input  logic [(NUM_CH-1)*DATA_W-1:0] aux_data,
    input  logic [(NUM_CH-1)*ADDR_W-1:0] aux_dest,
    output logic [NUM_CH-2:0]            aux_ready,
    output logic [NUM_CH-2:0]            aux_empty,
    output logic [DATA_W-1:0]            wb_write_data,
    output logic [ADDR_W-1:0]            wb_write_addr,
    output logic                         wb_reg_write,
    output logic                         wb_stall_req
);

    localparam int NA    = NUM_CH - 1;
    localparam int RR_W  = (NA > 1) ? $clog2(NA) : 1;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam int E_W   = ADDR_W + DATA_W;

    if (!params_ok(DATA_W, NUM_CH, FIFO_DEPTH) || STARVE_MAX < 1) begin : g_bad_params
        $error("wb_arbiter: illegal DATA_W, NUM_CH, FIFO_DEPTH or STARVE_MAX");
    end

    logic              ch0_elig;
    logic [DATA_W-1:0] ch0_data;
    logic [NA-1:0]     push, pop, full, empty;
    logic [E_W-1:0]    fifo_out [NA];
    logic              aux_gnt, any_aux, hit_hi, win;
    logic [RR_W-1:0]   sel, sel_hi, sel_lo;
    logic [RR_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall_q, stall_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;

    // Aux channels: dest-0 entries complete the handshake but are never stored
    for (genvar k = 0; k < NA; k++) begin : g_ch
        assign push[k] = aux_valid[k] & ~full[k] & (aux_dest[k*ADDR_W +: ADDR_W] != '0);
        wb_fifo #(.W(E_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   ({aux_dest[k*ADDR_W +: ADDR_W], aux_data[k*DATA_W +: DATA_W]}),
            .dout  (fifo_out[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    assign aux_ready = ~full;
    assign aux_empty = empty;

    // ch0 qualification and load formatting
    always_comb begin
        ch0_elig = p_valid & p_reg_write & (p_dest_reg != '0);
        ch0_data = p_mem_to_reg ?
                   DATA_W'(format_load(64'(p_mem_data), p_load_size, p_load_unsigned, 3'(p_byte_off))) :
                   p_alu_result;
    end

    // Round-robin pick among non-empty aux FIFOs starting at rr_q; ch0 pre-empts any aux grant
    always_comb begin
        hit_hi = 1'b0;
        sel_hi = '0;
        sel_lo = '0;
        for (int c = NA - 1; c >= 0; c--) begin
            if (!empty[c] && RR_W'(c) >= rr_q) begin
                hit_hi = 1'b1;
                sel_hi = RR_W'(c);
            end
            if (!empty[c]) sel_lo = RR_W'(c);
        end
        any_aux = ~&empty;
        sel     = hit_hi ? sel_hi : sel_lo;
        aux_gnt = any_aux & ~ch0_elig;
        pop     = aux_gnt ? (NA'(1) << sel) : '0;
        rr_d    = !aux_gnt ? rr_q : (sel == RR_W'(NA - 1)) ? '0 : sel + 1'b1;
    end

    // Starvation counter: counts cycles where queued aux work loses to ch0, saturating at STARVE_MAX
    always_comb begin
        cnt_d   = (aux_gnt | ~any_aux) ? '0 :
                  (ch0_elig && cnt_q != CNT_W'(STARVE_MAX)) ? cnt_q + 1'b1 : cnt_q;
        stall_d = cnt_d == CNT_W'(STARVE_MAX);
    end

    // Winner selection for the output register; data/address hold when nothing is written
    always_comb begin
        win    = ch0_elig | aux_gnt;
        we_d   = win;
        data_d = ch0_elig ? ch0_data : aux_gnt ? fifo_out[sel][DATA_W-1:0] : data_q;
        addr_d = ch0_elig ? p_dest_reg : aux_gnt ? fifo_out[sel][E_W-1:DATA_W] : addr_q;
    end

    // Arbiter state and registered write-port outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            we_q    <= we_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign wb_write_data = data_q;
    assign wb_write_addr = addr_q;
    assign wb_reg_write  = we_q;
    assign wb_stall_req  = stall_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table vectors, directed corner sequences and a randomized run against a queue-based model
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        p_valid, p_mem_to_reg, p_reg_write, p_load_unsigned;
    logic [31:0] p_mem_data, p_alu_result;
    logic [4:0]  p_dest_reg;
    logic [1:0]  p_load_size, p_byte_off;
    logic [1:0]  aux_valid, aux_ready, aux_empty;
    logic [63:0] aux_data;
    logic [9:0]  aux_dest;
    logic [31:0] wb_write_data;
    logic [4:0]  wb_write_addr;
    logic        wb_reg_write, wb_stall_req;

    always #5 clk = ~clk;

    wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_CH(3), .FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n), .p_valid(p_valid), .p_mem_data(p_mem_data),
        .p_alu_result(p_alu_result), .p_dest_reg(p_dest_reg), .p_mem_to_reg(p_mem_to_reg),
        .p_reg_write(p_reg_write), .p_load_size(p_load_size), .p_load_unsigned(p_load_unsigned),
        .p_byte_off(p_byte_off), .aux_valid(aux_valid), .aux_data(aux_data), .aux_dest(aux_dest),
        .aux_ready(aux_ready), .aux_empty(aux_empty), .wb_write_data(wb_write_data),
        .wb_write_addr(wb_write_addr), .wb_reg_write(wb_reg_write), .wb_stall_req(wb_stall_req)
    );

    int total = 0;
    int bad = 0;

    // Reference model: per-channel queues of {dest,data}, next-priority aux index, starvation count
    logic [36:0] mq [2][$];
    int          rr_m = 0;
    int          cnt_m = 0;
    logic        e_we;
    logic [31:0] e_data;
    logic [4:0]  e_addr;

    typedef struct {
        logic [31:0] mem;
        logic [31:0] alu;
        logic        m2r;
        logic [1:0]  sz;
        logic        uns;
        logic [1:0]  off;
        logic [4:0]  dest;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [31:0] mem, input logic [31:0] alu, input logic m2r,
                                        input logic [1:0] sz, input logic uns, input logic [1:0] off);
        int          nb;
        int          lane;
        logic [63:0] mask, v;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        lane = (int'(off) / nb) * nb;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = ({32'd0, mem} >> (8 * lane)) & mask;
        if (!uns && v[8 * nb - 1]) v = v | ~mask;
        return m2r ? v[31:0] : alu;
    endfunction

    task automatic idle();
        p_valid = 0; p_mem_data = 0; p_alu_result = 0; p_dest_reg = 0; p_mem_to_reg = 0;
        p_reg_write = 0; p_load_size = 0; p_load_unsigned = 0; p_byte_off = 0;
        aux_valid = 0; aux_data = 0; aux_dest = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) mq[k].delete();
        rr_m = 0;
        cnt_m = 0;
    endtask

    // One cycle: inputs are already driven (at a negedge); predict, clock, then compare
    task automatic step();
        logic [1:0]  rdy;
        logic        elig, any;
        int          win;
        int          kk;
        logic [36:0] ent;
        for (int k = 0; k < 2; k++) begin
            rdy[k] = mq[k].size() < 4;
            chk("aux_ready", aux_ready[k], rdy[k]);
            chk("aux_empty", aux_empty[k], mq[k].size() == 0);
        end
        elig = p_valid && p_reg_write && p_dest_reg != 0;
        any  = mq[0].size() != 0 || mq[1].size() != 0;
        win  = -1;
        e_we = 0;
        if (elig) begin
            e_we   = 1;
            e_data = fmt(p_mem_data, p_alu_result, p_mem_to_reg, p_load_size, p_load_unsigned, p_byte_off);
            e_addr = p_dest_reg;
        end else begin
            for (int i = 0; i < 2; i++) begin
                kk = (rr_m + i) % 2;
                if (win < 0 && mq[kk].size() != 0) win = kk;
            end
            if (win >= 0) begin
                ent    = mq[win].pop_front();
                e_we   = 1;
                e_data = ent[31:0];
                e_addr = ent[36:32];
                rr_m   = (win + 1) % 2;
            end
        end
        if (win >= 0 || !any) cnt_m = 0;
        else if (elig && cnt_m < 8) cnt_m++;
        for (int k = 0; k < 2; k++)
            if (aux_valid[k] && rdy[k] && aux_dest[k*5 +: 5] != 0)
                mq[k].push_back({aux_dest[k*5 +: 5], aux_data[k*32 +: 32]});
        @(posedge clk);
        @(negedge clk);
        chk("wb_reg_write", wb_reg_write, e_we);
        if (e_we) begin
            chk("wb_write_data", wb_write_data, e_data);
            chk("wb_write_addr", wb_write_addr, e_addr);
        end
        chk("wb_stall_req", wb_stall_req, cnt_m == 8);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    logic [4:0] got [4];

    initial begin
        idle();
        tbl[0]  = '{32'h80FF7F01, 32'h0, 1'b1, 2'd0, 1'b0, 2'd3, 5'd1,  32'hFFFFFF80};
        tbl[1]  = '{32'h80FF7F01, 32'h0, 1'b1, 2'd0, 1'b1, 2'd3, 5'd2,  32'h00000080};
        tbl[2]  = '{32'h80FF7F01, 32'h0, 1'b1, 2'd0, 1'b0, 2'd0, 5'd3,  32'h00000001};
        tbl[3]  = '{32'h80FF7F01, 32'h0, 1'b1, 2'd0, 1'b0, 2'd1, 5'd4,  32'h0000007F};
        tbl[4]  = '{32'h80FF7F01, 32'h0, 1'b1, 2'd0, 1'b0, 2'd2, 5'd5,  32'hFFFFFFFF};
        tbl[5]  = '{32'h80FF7F01, 32'h0, 1'b1, 2'd0, 1'b1, 2'd2, 5'd6,  32'h000000FF};
        tbl[6]  = '{32'h80FF7F01, 32'h0, 1'b1, 2'd1, 1'b0, 2'd2, 5'd7,  32'hFFFF80FF};
        tbl[7]  = '{32'h80FF7F01, 32'h0, 1'b1, 2'd1, 1'b1, 2'd2, 5'd8,  32'h000080FF};
        tbl[8]  = '{32'h80FF7F01, 32'h0, 1'b1, 2'd1, 1'b0, 2'd0, 5'd9,  32'h00007F01};
        tbl[9]  = '{32'h80FF7F01, 32'h0, 1'b1, 2'd1, 1'b0, 2'd3, 5'd10, 32'hFFFF80FF};
        tbl[10] = '{32'h80FF7F01, 32'h0, 1'b1, 2'd2, 1'b0, 2'd1, 5'd11, 32'h80FF7F01};
        tbl[11] = '{32'h80FF7F01, 32'h12345678, 1'b0, 2'd0, 1'b0, 2'd3, 5'd31, 32'h12345678};

        // Reset state
        #2 rst_n = 0;
        @(negedge clk);
        chk("rst wb_reg_write", wb_reg_write, 0);
        chk("rst wb_write_data", wb_write_data, 0);
        chk("rst wb_write_addr", wb_write_addr, 0);
        chk("rst wb_stall_req", wb_stall_req, 0);
        chk("rst aux_ready", aux_ready, 2'b11);
        chk("rst aux_empty", aux_empty, 2'b11);
        @(negedge clk);
        rst_n = 1;
        model_reset();

        // ch0 formatting vectors
        for (int i = 0; i < 12; i++) begin
            p_valid = 1; p_reg_write = 1;
            p_mem_data = tbl[i].mem; p_alu_result = tbl[i].alu; p_mem_to_reg = tbl[i].m2r;
            p_load_size = tbl[i].sz; p_load_unsigned = tbl[i].uns; p_byte_off = tbl[i].off;
            p_dest_reg = tbl[i].dest;
            step();
            chk("tbl data", wb_write_data, tbl[i].exp);
            chk("tbl addr", wb_write_addr, tbl[i].dest);
        end
        idle();
        step();

        // r0 suppression on ch0 and aux
        p_valid = 1; p_reg_write = 1; p_dest_reg = 0; p_alu_result = 32'hDEAD;
        aux_valid = 2'b01; aux_dest = 10'd0; aux_data = 64'h55;
        step();
        chk("r0 wb_reg_write", wb_reg_write, 0);
        chk("r0 aux_empty", aux_empty, 2'b11);
        idle();

        // Simultaneous ch0 and aux
        p_valid = 1; p_reg_write = 1; p_dest_reg = 5; p_alu_result = 32'h11;
        aux_valid = 2'b01; aux_dest = {5'd0, 5'd6}; aux_data = {32'd0, 32'h22};
        step();
        chk("sim ch0 addr", wb_write_addr, 5);
        chk("sim ch0 data", wb_write_data, 32'h11);
        idle();
        step();
        chk("sim aux we", wb_reg_write, 1);
        chk("sim aux addr", wb_write_addr, 6);
        chk("sim aux data", wb_write_data, 32'h22);

        // Round-robin: both aux FIFOs get two entries while ch0 wins, then ch0 goes idle
        do_reset();
        p_valid = 1; p_reg_write = 1; p_dest_reg = 3; p_alu_result = 32'h1;
        aux_valid = 2'b11; aux_dest = {5'd20, 5'd10}; aux_data = {32'h200, 32'h100};
        step();
        aux_dest = {5'd21, 5'd11}; aux_data = {32'h201, 32'h101};
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            got[i] = wb_write_addr;
        end
        chk("rr 0", got[0], 10);
        chk("rr 1", got[1], 20);
        chk("rr 2", got[2], 11);
        chk("rr 3", got[3], 21);

        // FIFO full and starvation
        do_reset();
        p_valid = 1; p_reg_write = 1; p_dest_reg = 1; p_alu_result = 32'hAA;
        aux_valid = 2'b01; aux_dest = {5'd0, 5'd7};
        for (int i = 1; i <= 9; i++) begin
            aux_data = {32'd0, 32'h700 + 32'(i)};
            step();
            if (i == 4) chk("full aux_ready", aux_ready[0], 0);
            if (i == 8) chk("stall early", wb_stall_req, 0);
            if (i == 9) chk("stall set", wb_stall_req, 1);
        end
        idle();
        step();
        chk("relief we", wb_reg_write, 1);
        chk("relief addr", wb_write_addr, 7);
        chk("relief data", wb_write_data, 32'h701);
        chk("relief stall", wb_stall_req, 0);
        chk("relief aux_ready", aux_ready[0], 1);

        // Asynchronous reset with three entries queued
        do_reset();
        p_valid = 1; p_reg_write = 1; p_dest_reg = 2; p_alu_result = 32'h9;
        aux_valid = 2'b01; aux_dest = {5'd0, 5'd9};
        for (int i = 0; i < 3; i++) begin
            aux_data = {32'd0, 32'h900 + 32'(i)};
            step();
        end
        chk("pre-rst we", wb_reg_write, 1);
        idle();
        #1 rst_n = 0;
        #1;
        chk("async rst we", wb_reg_write, 0);
        chk("async rst addr", wb_write_addr, 0);
        chk("async rst aux_empty", aux_empty, 2'b11);
        chk("async rst aux_ready", aux_ready, 2'b11);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post-rst no write", wb_reg_write, 0);
        end

        // Randomized run; the hazard unit mostly honours the stall request
        do_reset();
        for (int n = 0; n < 600; n++) begin
            p_valid = wb_stall_req ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
            p_reg_write = $urandom_range(0, 7) != 0;
            p_dest_reg = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            p_mem_data = $urandom;
            p_alu_result = $urandom;
            p_mem_to_reg = 1'($urandom_range(0, 1));
            p_load_size = 2'($urandom_range(0, 2));
            p_load_unsigned = 1'($urandom_range(0, 1));
            p_byte_off = 2'($urandom_range(0, 3));
            aux_valid = 2'($urandom_range(0, 3));
            aux_data = {$urandom, $urandom};
            aux_dest = {($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                        ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31))};
            step();
        end
        idle();
        for (int n = 0; n < 10; n++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
